// File: rtl/spike_out_pkg.sv
// Shared constants for the spike output queue: packet width default and drop counter sizing.
package spike_out_pkg;
  localparam int unsigned AER_BIT_WIDTH_DEF = 32;
  localparam int unsigned DROP_CNT_WIDTH    = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/spike_fifo_mem.sv
// Spike FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module spike_fifo_mem #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [PTR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [PTR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spike_out_queue.sv
// First-word-fall-through queue carrying fired-neuron AER packets to the router.
// Define SPIKE_OUT_DROP_CNT_EN to build the saturating dropped-spike counter.
module spike_out_queue
  import spike_out_pkg::*;
#(
  parameter int unsigned AER_BIT_WIDTH = AER_BIT_WIDTH_DEF,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PTR_WIDTH     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      outSpike_i,
  input  logic [AER_BIT_WIDTH-1:0]  SpikeAER_i,
  input  logic                      flush_i,
  output logic [AER_BIT_WIDTH-1:0]  pkt_o,
  output logic                      pkt_valid_o,
  input  logic                      pkt_ready_i,
  output logic [PTR_WIDTH:0]        count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push_c, pop_c;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_WIDTH'(DEPTH));
  assign pkt_valid_o = ~empty_o;
  assign count_o     = count_q;

  // A flush cycle swallows both push and pop.
  assign pop_c  = pkt_valid_o & pkt_ready_i & ~flush_i;
  assign push_c = outSpike_i & (~full_o | pop_c) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  spike_fifo_mem #(
    .WIDTH     (AER_BIT_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (SpikeAER_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (pkt_o)
  );

`ifdef SPIKE_OUT_DROP_CNT_EN
  logic                      drop_c;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // A spike lost to a full queue that is not draining this cycle.
  assign drop_c = outSpike_i & full_o & ~pop_c & ~flush_i;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != DROP_CNT_MAX)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/spike_out_queue.md
SPIKE_OUT_QUEUE -- requirements
Module: spike_out_queue

Interface
REQ-001 SHALL have parameter AER_BIT_WIDTH, default 32, the spike packet width.
REQ-002 SHALL have parameter DEPTH, default 4, the number of FIFO entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 SHALL have parameter PTR_WIDTH, default 2, equal to log2(DEPTH).
REQ-004 Ports:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- outSpike_i  in  1  neuron fired this cycle.
- SpikeAER_i  in  AER_BIT_WIDTH  packet of the firing neuron, valid with outSpike_i.
- flush_i  in  1  synchronous clear of queue contents.
- pkt_o  out  AER_BIT_WIDTH  packet to router.
- pkt_valid_o  out  1  pkt_o valid.
- pkt_ready_i  in  1  router accepts pkt_o.
- count_o  out  PTR_WIDTH+1  current occupancy.
- full_o  out  1  count_o==DEPTH.
- empty_o  out  1  count_o==0.
- drop_cnt_o  out  16  dropped-spike counter.

Function
REQ-005 Push SHALL occur when outSpike_i=1 and (full_o=0 or pop occurs in the same cycle); SpikeAER_i is written at the write pointer.
REQ-006 Pop SHALL occur when pkt_valid_o=1 and pkt_ready_i=1.
REQ-007 Queue SHALL be first-word-fall-through: pkt_o = entry at read pointer; pkt_valid_o = !empty_o.
REQ-008 Latency: a push into an empty queue at edge N SHALL give pkt_valid_o=1 with that packet after edge N.
REQ-009 While pkt_valid_o=1 and pkt_ready_i=0, pkt_o SHALL hold stable.
REQ-010 Packets SHALL leave in arrival order.
REQ-011 Read and write pointers SHALL be PTR_WIDTH bits and SHALL wrap from DEPTH-1 to 0.
REQ-012 Occupancy SHALL update as follows:
- push only: +1.
- pop only: -1.
- both, or neither: unchanged.
REQ-013 Simultaneous push and pop SHALL be legal at every occupancy: when full, both are accepted; when empty, only the push occurs because no pop is possible.
REQ-014 outSpike_i=1 with full_o=1 and no pop SHALL drop the packet and leave queue state unchanged.
REQ-015 flush_i=1 SHALL clear the pointers and count at the next edge, and SHALL ignore push and pop in that cycle. drop_cnt_o is not cleared.
REQ-016 SpikeAER_i SHALL be ignored when outSpike_i=0.

Reset
REQ-017 rst_i=1 SHALL asynchronously force:
- pointers and count to 0.
- pkt_valid_o=0, empty_o=1, full_o=0.
- drop_cnt_o=0.
REQ-018 FIFO storage SHALL not be reset; pkt_o is don't-care while pkt_valid_o=0.
REQ-019 Reset asserted mid-transfer SHALL discard all queued packets, and the first edge after deassertion SHALL accept a push normally.

Configuration
REQ-020 With macro SPIKE_OUT_DROP_CNT_EN defined:
- drop_cnt_o SHALL increment by 1 on each drop (REQ-014).
- drop_cnt_o SHALL saturate at 16'hFFFF.
REQ-021 Without SPIKE_OUT_DROP_CNT_EN, drop_cnt_o SHALL be constant 0 and no counter register SHALL be built.

Structure
REQ-022 Package spike_out_pkg SHALL hold:
- AER_BIT_WIDTH default.
- DROP_CNT_WIDTH=16.
- the saturation constant.
REQ-023 Storage SHALL be a sub-module spike_fifo_mem: DEPTH x AER_BIT_WIDTH, one write port, one asynchronous read port. Pointer and count control SHALL stay in spike_out_queue.

Verification
REQ-024 Reset, then a single spike with SpikeAER_i=32'h0011_0003 and pkt_ready_i=1 -> next cycle pkt_valid_o=1, pkt_o=32'h0011_0003; the following cycle empty_o=1.
REQ-025 pkt_ready_i=0, push 4 packets A,B,C,D, then a 5th spike E -> full_o=1, count_o=4, drop_cnt_o=1 (macro on) or 0 (macro off). Then pkt_ready_i=1 -> pops in order A,B,C,D and E is never seen.
REQ-026 Full queue with pkt_ready_i=1 and outSpike_i=1 in the same cycle -> count_o stays 4, the head advances, and the new packet appears last.
REQ-027 Push 6 and pop 6, interleaved over 10 cycles -> pointers wrap and order is preserved with no loss.
REQ-028 Queue holding 3 entries, then flush_i=1 together with outSpike_i=1 -> next cycle count_o=0 and empty_o=1; drop_cnt_o is unchanged.
REQ-029 Assert rst_i asynchronously between edges with 2 entries queued -> pkt_valid_o falls immediately; a push after release yields the new packet first.
